mips_data_mem_responder: RTL and testbench

Single-port data-memory responder serving load/store requests from the pipelined MIPS core's MEM stage over a valid/ready request channel and a valid/ready response channel. It holds the word-addressed data array, returns read data after a fixed pipeline latency, and acknowledges every write. Backpressure is credit-based, so accepted responses can never be dropped.

---
 rtl/mips_data_mem_responder_if.sv | 24 ++
 rtl/mips_data_mem_responder.sv | 95 +++++++++
 tb/tb_mips_data_mem_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_data_mem_responder_if.sv
// Request/response channel between the MIPS MEM stage (master) and the data-memory responder (slave).
// Both directions use valid/ready handshakes; clock and reset stay outside the bundle.
interface mips_data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_we;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
   );
endinterface

// File: rtl/mips_data_mem_responder.sv
// Word-addressed data memory with a fixed-latency read pipeline feeding an in-order response FIFO.
// Credit counting (outstanding requests <= DEPTH) guarantees the FIFO never overflows.
module mips_data_mem_responder #(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic                     clk1,
   input  logic                     rst,
   mips_data_mem_responder_if.slave bus
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]       r_mem   [2**ADDR_W];
   logic              r_pv    [LATENCY];
   logic              r_pwe   [LATENCY];
   logic              r_perr  [LATENCY];
   logic [31:0]       r_pdata [LATENCY];
   logic [31:0]       r_fdata [DEPTH];
   logic              r_fwe   [DEPTH];
   logic              r_ferr  [DEPTH];
   logic [CNT_W-1:0]  r_out_cnt;
   logic [CNT_W-1:0]  r_fcnt;
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;

   logic              w_accept;
   logic              w_in_range;
   logic              w_push;
   logic              w_pop;
   logic [ADDR_W-1:0] w_idx;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign w_accept   = bus.req_valid && bus.req_ready;
   assign w_in_range = (bus.req_addr[31:ADDR_W] == '0);
   assign w_idx      = bus.req_addr[ADDR_W-1:0];
   assign w_push     = r_pv[LATENCY-1];
   assign w_pop      = bus.rsp_valid && bus.rsp_ready;

   // Ready comes only from the registered credit count, so it never depends on rsp_ready.
   assign bus.req_ready = (r_out_cnt < CNT_W'(DEPTH));
   assign bus.rsp_valid = (r_fcnt != '0);
   assign bus.rsp_rdata = bus.rsp_valid ? r_fdata[r_rptr] : '0;
   assign bus.rsp_we    = bus.rsp_valid && r_fwe[r_rptr];
   assign bus.rsp_err   = bus.rsp_valid && r_ferr[r_rptr];

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         r_out_cnt <= '0;
         r_fcnt    <= '0;
         r_wptr    <= '0;
         r_rptr    <= '0;
         for (int k = 0; k < LATENCY; k++) r_pv[k] <= 1'b0;
      end else begin
         r_pv[0] <= w_accept;
         for (int k = 1; k < LATENCY; k++) r_pv[k] <= r_pv[k-1];

         if (w_accept && !w_pop)      r_out_cnt <= r_out_cnt + CNT_W'(1);
         else if (!w_accept && w_pop) r_out_cnt <= r_out_cnt - CNT_W'(1);

         if (w_push && !w_pop)      r_fcnt <= r_fcnt + CNT_W'(1);
         else if (!w_push && w_pop) r_fcnt <= r_fcnt - CNT_W'(1);

         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      end
   end

   // Array contents are intentionally never reset and survive rst.
   always_ff @(posedge clk1) begin
      if (w_accept && bus.req_we && w_in_range) r_mem[w_idx] <= bus.req_wdata;
   end

   always_ff @(posedge clk1) begin
      r_pdata[0] <= r_mem[w_idx];
      r_pwe[0]   <= bus.req_we;
      r_perr[0]  <= !w_in_range;
      for (int k = 1; k < LATENCY; k++) begin
         r_pdata[k] <= r_pdata[k-1];
         r_pwe[k]   <= r_pwe[k-1];
         r_perr[k]  <= r_perr[k-1];
      end

      // Stores and errors carry zero data; the raw array read is discarded here.
      if (w_push) begin
         r_fdata[r_wptr] <= (r_pwe[LATENCY-1] || r_perr[LATENCY-1]) ? '0 : r_pdata[LATENCY-1];
         r_fwe[r_wptr]   <= r_pwe[LATENCY-1];
         r_ferr[r_wptr]  <= r_perr[LATENCY-1];
      end
   end
endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Directed bench for mips_data_mem_responder: table vectors, backpressure, mid-flight reset, streaming.
module tb_mips_data_mem_responder;
   localparam int ADDR_W  = 10;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;

   logic clk1 = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   mips_data_mem_responder_if bus ();

   mips_data_mem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .clk1 (clk1),
      .rst  (rst),
      .bus  (bus)
   );

   always #5 clk1 = ~clk1;
   always @(posedge clk1) cyc <= cyc + 1;

   typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } req_t;
   typedef struct { logic [31:0] rdata; logic we; logic err; } rsp_t;
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_we;
      logic        exp_err;
   } vec_t;

   req_t        q_req[$];
   rsp_t        q_exp[$];
   int          q_acc[$];
   logic [31:0] mdl [16];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drives queued requests with rsp_ready high, checking each response in order.
   task automatic run_q(input string tag, input bit use_model, input bit chk_lat,
                        input int budget, output int stalls);
      int   n;
      int   acc_edge;
      bit   acc;
      rsp_t e;
      req_t r;
      int   a;
      n = 0;
      stalls = 0;
      bus.rsp_ready = 1'b1;
      while (q_req.size() != 0 || q_acc.size() != 0) begin
         if (q_req.size() != 0) begin
            bus.req_valid = 1'b1;
            bus.req_we    = q_req[0].we;
            bus.req_addr  = q_req[0].addr;
            bus.req_wdata = q_req[0].wdata;
         end else begin
            bus.req_valid = 1'b0;
         end
         if (bus.rsp_valid) begin
            if (q_exp.size() == 0 || q_acc.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL %s unexpected response: got rdata=0x%0h required none", tag, bus.rsp_rdata);
            end else begin
               e = q_exp.pop_front();
               a = q_acc.pop_front();
               chk({tag, " rsp{we,err,rdata}"}, {30'b0, bus.rsp_we, bus.rsp_err, bus.rsp_rdata},
                   {30'b0, e.we, e.err, e.rdata});
               if (chk_lat) chk({tag, " latency"}, 64'(cyc - a), 64'(LATENCY));
            end
         end
         acc      = bus.req_valid && bus.req_ready;
         acc_edge = cyc + 1;
         if (bus.req_valid && !bus.req_ready) stalls++;
         @(posedge clk1);
         if (acc) begin
            r = q_req.pop_front();
            q_acc.push_back(acc_edge);
            if (use_model) begin
               if (r.addr[31:ADDR_W] != '0) begin
                  e = '{32'h0, r.we, 1'b1};
               end else if (r.we) begin
                  mdl[r.addr[3:0]] = r.wdata;
                  e = '{32'h0, 1'b1, 1'b0};
               end else begin
                  e = '{mdl[r.addr[3:0]], 1'b0, 1'b0};
               end
               q_exp.push_back(e);
            end
         end
         @(negedge clk1);
         n++;
         if (n > budget) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: got %0d pending required 0", tag, q_req.size() + q_acc.size());
            q_req.delete();
            q_acc.delete();
            q_exp.delete();
         end
      end
      bus.req_valid = 1'b0;
      if (q_exp.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s missing responses: got %0d leftover required 0", tag, q_exp.size());
         q_exp.delete();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[16];
      int   stalls;
      int   acc;
      bit   a;
      req_t r;

      tbl[0]  = '{1'b1, 32'd5,        32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
      tbl[1]  = '{1'b0, 32'd5,        32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 32'd0,        32'h0000A5A5, 32'h0,        1'b1, 1'b0};
      tbl[3]  = '{1'b0, 32'h400,      32'h0,        32'h0,        1'b0, 1'b1};
      tbl[4]  = '{1'b1, 32'h400,      32'h12345678, 32'h0,        1'b1, 1'b1};
      tbl[5]  = '{1'b0, 32'd0,        32'h0,        32'h0000A5A5, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 32'd5,        32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
      tbl[7]  = '{1'b1, 32'h3FF,      32'hCAFEF00D, 32'h0,        1'b1, 1'b0};
      tbl[8]  = '{1'b0, 32'h3FF,      32'h0,        32'hCAFEF00D, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 32'h80000005, 32'h0,        32'h0,        1'b0, 1'b1};
      for (int i = 0; i < 6; i++)
         tbl[10+i] = '{1'b1, 32'(20 + i), 32'(32'h1000 + i), 32'h0, 1'b1, 1'b0};

      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk1);
      chk("reset req_ready", 64'(bus.req_ready), 64'd1);
      chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("reset rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      chk("reset rsp_we",    64'(bus.rsp_we),    64'd0);
      chk("reset rsp_err",   64'(bus.rsp_err),   64'd0);
      rst = 1'b0;
      @(negedge clk1);

      foreach (tbl[i]) begin
         q_req.push_back('{tbl[i].we, tbl[i].addr, tbl[i].wdata});
         q_exp.push_back('{tbl[i].exp_rdata, tbl[i].exp_we, tbl[i].exp_err});
         run_q($sformatf("vec%0d", i), 1'b0, 1'b1, 20, stalls);
      end

      // Store then load of the same word on consecutive edges.
      q_req.push_back('{1'b1, 32'd7, 32'h11});
      q_req.push_back('{1'b0, 32'd7, 32'h0});
      q_exp.push_back('{32'h0,  1'b1, 1'b0});
      q_exp.push_back('{32'h11, 1'b0, 1'b0});
      run_q("b2b", 1'b0, 1'b1, 20, stalls);
      chk("b2b stalls", 64'(stalls), 64'd0);

      // Six loads offered against a stalled response channel.
      bus.rsp_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         if (acc < 6) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = 32'(20 + acc);
         end else begin
            bus.req_valid = 1'b0;
         end
         a = bus.req_valid && bus.req_ready;
         @(posedge clk1);
         @(negedge clk1);
         if (a) acc++;
      end
      chk("bp accepted", 64'(acc), 64'd4);
      chk("bp req_ready", 64'(bus.req_ready), 64'd0);
      chk("bp rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp head stable", 64'(bus.rsp_rdata), 64'h1000);
      bus.rsp_ready = 1'b1;
      #1;
      chk("bp ready no comb path", 64'(bus.req_ready), 64'd0);
      q_req.push_back('{1'b0, 32'd24, 32'h0});
      q_req.push_back('{1'b0, 32'd25, 32'h0});
      for (int i = 0; i < 6; i++) q_exp.push_back('{32'(32'h1000 + i), 1'b0, 1'b0});
      for (int i = 0; i < 4; i++) q_acc.push_back(0);
      run_q("drain", 1'b0, 1'b0, 40, stalls);
      chk("drain stalls", 64'(stalls), 64'd1);

      // Reset with three loads in flight.
      bus.rsp_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         bus.req_valid = 1'b1;
         bus.req_we    = 1'b0;
         bus.req_addr  = 32'd5;
         @(posedge clk1);
         @(negedge clk1);
      end
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk1);
      chk("pre-reset rsp_valid", 64'(bus.rsp_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("mid-reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("mid-reset req_ready", 64'(bus.req_ready), 64'd1);
      @(negedge clk1);
      rst = 1'b0;
      @(negedge clk1);
      q_req.push_back('{1'b0, 32'd5, 32'h0});
      q_exp.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
      run_q("post-reset", 1'b0, 1'b1, 20, stalls);

      // Seed words 0..15, then stream random traffic against the model.
      for (int i = 0; i < 16; i++) q_req.push_back('{1'b1, 32'(i), $urandom});
      run_q("fill", 1'b1, 1'b1, 100, stalls);
      for (int i = 0; i < 100; i++) begin
         r.we    = 1'($urandom_range(0, 1));
         r.addr  = ($urandom_range(0, 7) == 0) ? (32'h400 | 32'($urandom_range(0, 15)))
                                               : 32'($urandom_range(0, 15));
         r.wdata = $urandom;
         q_req.push_back(r);
      end
      run_q("stream", 1'b1, 1'b1, 400, stalls);
      chk("stream stalls", 64'(stalls), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
